// File: rtl/muldiv_hilo_pkg.sv
// Shared opcode and FSM state encodings for the HI/LO multiply/divide unit.
package muldiv_hilo_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_hilo_div_iter.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset (control only)
//   start             load dividend/divisor and begin WIDTH iterations
//   abort             drop the division in flight
//   dividend, divisor unsigned operands, sampled on start
//   quotient          unsigned quotient
//   remainder         unsigned remainder
//   valid             high once WIDTH iterations have completed
// A zero divisor needs no special case: every trial subtraction succeeds, so
// the quotient comes out all-ones and the remainder equals the dividend.
module muldiv_hilo_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic          running;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem_r, quo_r, dsr_r;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             fits;

  // Trial subtraction: bring down the next dividend bit and compare.
  always_comb begin
    rem_shift = {rem_r, quo_r[WIDTH-1]};
    fits      = (rem_shift >= {1'b0, dsr_r});
    rem_sub   = rem_shift[WIDTH-1:0] - dsr_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CW'(WIDTH);
    end else if (abort) begin
      running <= 1'b0;
    end else if (running) begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      else           running <= 1'b0;
    end
  end

  // Quotient bits shift in where dividend bits shift out.
  always_ff @(posedge clk) begin
    if (start) begin
      rem_r <= '0;
      quo_r <= dividend;
      dsr_r <= divisor;
    end else if (running && cnt != '0) begin
      rem_r <= fits ? rem_sub : rem_shift[WIDTH-1:0];
      quo_r <= {quo_r[WIDTH-2:0], fits};
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;
  assign valid     = running && (cnt == '0);

endmodule

// File: rtl/muldiv_hilo.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start, op     request and opcode (MULT/MULTU/DIV/DIVU/MTHI/MTLO, 6/7 no-op)
//   a, b          operands, latched when the request is accepted
//   cancel        aborts any operation in flight and blocks a same-cycle start
//   ready, busy   handshake status (ready = !busy)
//   done          one-cycle completion pulse, HI/LO already updated
//   hi, lo        HI/LO registers
module muldiv_hilo
  import muldiv_hilo_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_sgn);
    return (is_sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  md_state_e          state;
  md_op_e             op_e;
  logic [CNT_W-1:0]   mul_cnt;
  logic               accept, is_signed, is_div, div_start;
  logic signed [2*WIDTH-1:0] a_ext, b_ext;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_p0;
  logic               q_neg_p0, r_neg_p0, div_zero_p0;
  logic [WIDTH-1:0]   a_p0;
  logic [WIDTH-1:0]   div_q, div_r;
  logic               div_valid;

  assign busy   = (state != MD_IDLE);
  assign ready  = !busy;
  assign op_e   = md_op_e'(op);
  assign accept = start && !busy && !cancel;

  // Operand conditioning: sign/zero extend to 2*WIDTH so a single truncated
  // multiply serves both signed and unsigned products.
  always_comb begin
    is_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
    is_div    = (op_e == OP_DIV) || (op_e == OP_DIVU);
    div_start = accept && is_div;
    a_ext     = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext     = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    product   = a_ext * b_ext;
  end

  // ---- accept edge: capture product and divide sign/zero context ----
  always_ff @(posedge clk) begin
    if (accept) begin
      prod_p0     <= product;
      q_neg_p0    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg_p0    <= is_signed && a[WIDTH-1];
      div_zero_p0 <= (b == '0);
      a_p0        <= a;
    end
  end

  muldiv_hilo_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (cancel),
    .dividend  (magnitude(a, is_signed)),
    .divisor   (magnitude(b, is_signed)),
    .quotient  (div_q),
    .remainder (div_r),
    .valid     (div_valid)
  );

  // ---- completion edge: FSM, HI/LO write and done pulse ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MD_IDLE;
      mul_cnt <= '0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (accept) begin
            case (op_e)
              OP_MULT, OP_MULTU: begin
                state   <= MD_MUL;
                mul_cnt <= CNT_W'(MUL_CYCLES - 1);
              end
              OP_DIV, OP_DIVU: state <= MD_DIV;
              OP_MTHI:         hi <= a;
              OP_MTLO:         lo <= a;
              default:         ;
            endcase
          end
        end
        MD_MUL: begin
          if (cancel) begin
            state <= MD_IDLE;
          end else if (mul_cnt == '0) begin
            {hi, lo} <= prod_p0;
            done     <= 1'b1;
            state    <= MD_IDLE;
          end else begin
            mul_cnt <= mul_cnt - CNT_W'(1);
          end
        end
        MD_DIV: begin
          if (cancel) begin
            state <= MD_IDLE;
          end else if (div_valid) begin
            // Divide by zero reports the original (signed) dividend, not its magnitude.
            if (div_zero_p0) begin
              lo <= '1;
              hi <= a_p0;
            end else begin
              lo <= apply_sign(div_q, q_neg_p0);
              hi <= apply_sign(div_r, r_neg_p0);
            end
            done  <= 1'b1;
            state <= MD_IDLE;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
module tb_muldiv_hilo;

  localparam int W  = 32;
  localparam int MC = 2;

  logic         clk = 1'b0;
  logic         rst, start, cancel;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         ready, busy, done;
  logic [W-1:0] hi, lo;

  muldiv_hilo #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] m_hi, m_lo;
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: architectural results straight from integer arithmetic.
  function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] x, y,
                                    output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint          sp;
    longint unsigned up;
    int              sx, sy;
    rh = m_hi;
    rl = m_lo;
    sx = x;
    sy = y;
    case (o)
      3'd0: begin sp = longint'(sx) * longint'(sy); {rh, rl} = sp; end
      3'd1: begin up = {32'd0, x} * {32'd0, y}; {rh, rl} = up; end
      3'd2: begin
        if (y == 0)                                   begin rl = '1; rh = x; end
        else if (x == 32'h8000_0000 && y == '1)       begin rl = x;  rh = '0; end
        else                                          begin rl = sx / sy; rh = sx % sy; end
      end
      3'd3: begin
        if (y == 0) begin rl = '1; rh = x; end
        else        begin rl = x / y; rh = x % y; end
      end
      default: ;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  exp_t e;
  always @(negedge clk) begin
    if (!rst && done) begin
      check("done_expected", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("done_cycle", cyc, e.due);
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, y, input bit keep);
    int           guard;
    logic [W-1:0] eh, el;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("ready_timeout", ready, 1);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    ref_model(o, x, y, eh, el);
    case (o)
      3'd0, 3'd1: begin
        check("mul_busy", busy, 1);
        if (keep) sb_q.push_back('{eh, el, cyc + MC});
      end
      3'd2, 3'd3: begin
        check("div_busy", busy, 1);
        if (keep) sb_q.push_back('{eh, el, cyc + W + 1});
      end
      3'd4: begin
        m_hi = x;
        check("mthi_hi", hi, x);
        check("mthi_busy", busy, 0);
      end
      3'd5: begin
        m_lo = x;
        check("mtlo_lo", lo, x);
        check("mtlo_busy", busy, 0);
      end
      default: begin
        check("rsv_hi", hi, m_hi);
        check("rsv_lo", lo, m_lo);
        check("rsv_busy", busy, 0);
      end
    endcase
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb_q.size() != 0 || busy) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) check("drain_timeout", sb_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", ready, 1);
    rst = 1'b0;

    // Multiply, signed and unsigned
    issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1);
    issue(3'd1, 32'hFFFF_FFFD, 32'd7, 1);
    drain();

    // Divide: plain, signed, overflow corner, zero divisor
    issue(3'd3, 32'd100, 32'd7, 1);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(3'd2, 32'hFFFF_FFFB, 32'd0, 1);
    issue(3'd3, 32'hFFFF_FFFB, 32'd0, 1);
    issue(3'd2, 32'd7, 32'hFFFF_FFFE, 1);
    drain();

    // Cancel a divide in its 10th busy cycle
    issue(3'd2, 32'd1000, 32'd3, 0);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_ready", ready, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("cancel_no_done", done, 0);
    end
    check("cancel_hi", hi, m_hi);
    check("cancel_lo", lo, m_lo);

    // Cancel exactly at the final edge of a divide
    issue(3'd3, 32'd12345, 32'd11, 0);
    repeat (W + 1) @(negedge clk);
    check("final_busy", busy, 1);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("final_cancel_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("final_no_done", done, 0);
    end
    check("final_hi", hi, m_hi);
    check("final_lo", lo, m_lo);

    // Cancel together with start in IDLE drops the request
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    check("cs_hi", hi, m_hi);
    check("cs_busy", busy, 0);

    // MTHI then MTLO on consecutive cycles
    issue(3'd4, 32'h1234_5678, 32'd0, 0);
    issue(3'd5, 32'h9ABC_DEF0, 32'd0, 0);

    // Start while a divide is busy is ignored
    issue(3'd2, 32'hF000_1234, 32'd77, 1);
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hFFFF_0000; b = 32'd1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    drain();
    check("ignored_start_hi", hi, m_hi);

    // Reset in the middle of a multiply
    issue(3'd0, 32'd3, 32'd5, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;

    // Back-to-back: second start accepted in the done cycle of the first
    issue(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1);
    t0 = cyc;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    check("b2b_accept_cycle", cyc, t0 + MC + 1);
    t0 = cyc;
    issue(3'd2, 32'h8000_0001, 32'd3, 1);
    check("b2b_mul_div_cycle", cyc, t0 + MC + 1);
    issue(3'd3, 32'hFFFF_FFFF, 32'd16, 1);
    drain();

    // Randomised mix including corner operands and reserved opcodes
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 9))
        0: ry = '0;
        1: begin rx = 32'h8000_0000; ry = '1; end
        2: ry = 32'($urandom_range(1, 9));
        3: rx = 32'($urandom_range(0, 50));
        default: ;
      endcase
      issue(ro, rx, ry, 1);
    end
    drain();
    check("final_model_hi", hi, m_hi);
    check("final_model_lo", lo, m_lo);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
